// File: rtl/execute_stage.sv
// Execute stage of a five-stage RV32I-style pipeline.
// Selects forwarded operands, runs the ALU, resolves branches/jumps in the same
// cycle and holds the EX/MEM pipeline register that feeds the memory stage.
// The memory-stage ALU value used for forwarding is this stage's own EX/MEM
// register, so back-to-back dependencies resolve without a stall.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    // decoded controls from the ID/EX register
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  ALUControlE,
    // operands and PC values
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    // forwarding sources and selects
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    // same-cycle redirect to fetch
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    // EX/MEM register outputs
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALUResultM
);

    // Forwarding select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Three-way operand forwarding mux; the unused 11 code falls back to the
    // register-file value so a corrupted select never injects stale data.
    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] wb_val,
        input logic [31:0] mem_val
    );
        logic [31:0] res;
        case (sel)
            FWD_REG: res = reg_val;
            FWD_WB:  res = wb_val;
            FWD_MEM: res = mem_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    // Integer ALU; add/sub wrap modulo 2^32, comparisons return 1/0.
    function automatic logic [31:0] alu_op(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] res;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  res = a << b[4:0];
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    // Combinational datapath signals
    logic [31:0] src_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] src_b_s;
    logic [31:0] alu_result_s;
    logic        zero_s;

    // EX/MEM register state
    logic        reg_write_r;
    logic        mem_write_r;
    logic [1:0]  result_src_r;
    logic [4:0]  rd_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] write_data_r;
    logic [31:0] alu_result_r;

    // Operand forwarding, immediate select and ALU evaluation
    always_comb begin
        src_a_s      = fwd_mux(ForwardA_E, RD1_E, ResultW, alu_result_r);
        fwd_b_s      = fwd_mux(ForwardB_E, RD2_E, ResultW, alu_result_r);
        src_b_s      = fwd_b_s;
        if (ALUSrcE) begin
            src_b_s = ImmExtE;
        end else begin
            src_b_s = fwd_b_s;
        end
        alu_result_s = alu_op(ALUControlE, src_a_s, src_b_s);
        if (alu_result_s == 32'h0000_0000) begin
            zero_s = 1'b1;
        end else begin
            zero_s = 1'b0;
        end
    end

    // Branch/jump resolution; target uses the raw immediate, never forwarded data
    always_comb begin
        PCSrcE    = JumpE | (BranchE & zero_s);
        PCTargetE = PCE + ImmExtE;
    end

    // EX/MEM pipeline register: loads every cycle, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            result_src_r <= 2'b00;
            rd_r         <= 5'd0;
            pc_plus4_r   <= 32'd0;
            write_data_r <= 32'd0;
            alu_result_r <= 32'd0;
        end else begin
            reg_write_r  <= RegWriteE;
            mem_write_r  <= MemWriteE;
            result_src_r <= ResultSrcE;
            rd_r         <= RD_E;
            pc_plus4_r   <= PCPlus4E;
            write_data_r <= fwd_b_s;
            alu_result_r <= alu_result_s;
        end
    end

    // Registered outputs straight from the EX/MEM register
    assign RegWriteM  = reg_write_r;
    assign MemWriteM  = mem_write_r;
    assign ResultSrcM = result_src_r;
    assign RD_M       = rd_r;
    assign PCPlus4M   = pc_plus4_r;
    assign WriteDataM = write_data_r;
    assign ALUResultM = alu_result_r;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: every clocked operation pushes its
// expected EX/MEM contents, which are popped and compared after the edge.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALUResultM;

    typedef struct packed {
        logic        regw;
        logic        memw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
    } m_t;

    m_t          sb[$];
    logic [31:0] mdl_alu_m;
    int          vectors;
    int          miscompares;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ResultW(ResultW), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALUResultM(ALUResultM)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU written from the operation table
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a + (~b) + 32'd1;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    r = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            3'd7:    r = a << b[4:0];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Reference forwarding selection
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
        logic [31:0] r;
        if (sel == 2'b01)      r = wb;
        else if (sel == 2'b10) r = mem;
        else                   r = rf;
        return r;
    endfunction

    function automatic m_t dut_m();
        m_t g;
        g = '{RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALUResultM};
        return g;
    endfunction

    task automatic clear_inputs();
        RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        ALUSrcE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 3'b000;
        RD1_E = 32'd0; RD2_E = 32'd0; ImmExtE = 32'd0; PCE = 32'd0;
        PCPlus4E = 32'd0; ResultW = 32'd0; RD_E = 5'd0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    // Push the expected EX/MEM contents for current inputs, clock, pop and sample
    task automatic run_cycle(output m_t exp, output m_t got);
        m_t          e;
        logic [31:0] a, fb, b;
        a  = ref_fwd(ForwardA_E, RD1_E, ResultW, mdl_alu_m);
        fb = ref_fwd(ForwardB_E, RD2_E, ResultW, mdl_alu_m);
        b  = ALUSrcE ? ImmExtE : fb;
        e  = '{RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, fb, ref_alu(ALUControlE, a, b)};
        sb.push_back(e);
        mdl_alu_m = e.alu;
        @(posedge clk);
        #1;
        got = dut_m();
        if (sb.size() == 0) begin
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        m_t g;
        clear_inputs();
        rst = 1'b0;
        #1;
        g = dut_m();
        vectors++;
        if (g !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h required 0", g);
        end
        RegWriteE = 1'b1; MemWriteE = 1'b1; RD_E = 5'd9; RD1_E = 32'd3; PCPlus4E = 32'h44;
        @(posedge clk); #1;
        g = dut_m();
        vectors++;
        if (g !== '0) begin
            miscompares++;
            $display("FAIL reset_held_over_edge: got %h required 0", g);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        mdl_alu_m = 32'd0;
        sb.delete();
    endtask

    task automatic test_add();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        RD1_E = 32'd5; RD2_E = 32'd7; RegWriteE = 1'b1; RD_E = 5'd3; PCPlus4E = 32'h104;
        run_cycle(e, g);
        vectors++;
        if (g !== e || ALUResultM !== 32'd12 || RD_M !== 5'd3 || RegWriteM !== 1'b1) begin
            miscompares++;
            $display("FAIL add_basic: got alu=%h rd=%0d regw=%b required alu=0000000c rd=3 regw=1", ALUResultM, RD_M, RegWriteM);
        end
    endtask

    task automatic test_forwarding();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        RD1_E = 32'h10; RD2_E = 32'h0;
        run_cycle(e, g);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL fwd_setup: got alu=%h required %h", g.alu, e.alu);
        end
        @(negedge clk);
        RD1_E = 32'h1; ResultW = 32'h20; ImmExtE = 32'h4; ALUSrcE = 1'b1;
        ALUControlE = 3'b001; ForwardA_E = 2'b10;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'hC) begin
            miscompares++;
            $display("FAIL fwd_from_mem: got alu=%h required 0000000c", g.alu);
        end
        @(negedge clk);
        ForwardA_E = 2'b01;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'h1C) begin
            miscompares++;
            $display("FAIL fwd_from_wb: got alu=%h required 0000001c", g.alu);
        end
        @(negedge clk);
        ForwardA_E = 2'b11;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL fwd_code_11: got alu=%h required fffffffd", g.alu);
        end
    endtask

    task automatic test_branch();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        BranchE = 1'b1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        vectors++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin
            miscompares++;
            $display("FAIL branch_taken: got pcsrc=%b target=%h required 1 000000f8", PCSrcE, PCTargetE);
        end
        RD2_E = 32'd8;
        #1;
        vectors++;
        if (PCSrcE !== 1'b0 || PCTargetE !== 32'hF8) begin
            miscompares++;
            $display("FAIL branch_not_taken: got pcsrc=%b target=%h required 0 000000f8", PCSrcE, PCTargetE);
        end
        BranchE = 1'b0; JumpE = 1'b1;
        #1;
        vectors++;
        if (PCSrcE !== 1'b1) begin
            miscompares++;
            $display("FAIL jump: got pcsrc=%b required 1", PCSrcE);
        end
        run_cycle(e, g);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL branch_capture: got %h required %h", g, e);
        end
    endtask

    task automatic test_store();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        RD1_E = 32'h55;
        run_cycle(e, g);
        @(negedge clk);
        MemWriteE = 1'b1; RD1_E = 32'h1000; RD2_E = 32'hAA; ForwardB_E = 2'b10;
        ALUSrcE = 1'b1; ImmExtE = 32'h8; ResultSrcE = 2'b01;
        run_cycle(e, g);
        vectors++;
        if (g !== e || WriteDataM !== 32'h55 || MemWriteM !== 1'b1) begin
            miscompares++;
            $display("FAIL store_fwd_data: got wd=%h memw=%b required 00000055 1", WriteDataM, MemWriteM);
        end
    endtask

    task automatic test_compare_ops();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControlE = 3'b101;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'd1) begin
            miscompares++;
            $display("FAIL slt_signed: got %h required 00000001", g.alu);
        end
        @(negedge clk);
        ALUControlE = 3'b110;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'd0) begin
            miscompares++;
            $display("FAIL sltu: got %h required 00000000", g.alu);
        end
        @(negedge clk);
        ALUControlE = 3'b000; BranchE = 1'b1;
        #1;
        vectors++;
        if (PCSrcE !== 1'b1) begin
            miscompares++;
            $display("FAIL add_wrap_zero: got pcsrc=%b required 1", PCSrcE);
        end
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.alu !== 32'd0) begin
            miscompares++;
            $display("FAIL add_wrap: got %h required 00000000", g.alu);
        end
    endtask

    task automatic test_alu_ops();
        m_t e, g;
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            clear_inputs();
            RD1_E = 32'h8000_00F1; RD2_E = 32'h0000_0023; ALUControlE = op[2:0];
            ForwardA_E = op[0] ? 2'b11 : 2'b00;
            RD_E = op[4:0] + 5'd1; RegWriteE = 1'b1;
            run_cycle(e, g);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL alu_op_%0d: got alu=%h rd=%0d required alu=%h rd=%0d", op, g.alu, g.rd, e.alu, e.rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        m_t e, g;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
            ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom);
            RD1_E = $urandom; RD2_E = $urandom; ImmExtE = $urandom;
            PCPlus4E = $urandom; ResultW = $urandom; RD_E = 5'($urandom);
            ForwardA_E = (i % 3 == 0) ? 2'b10 : 2'($urandom);
            ForwardB_E = 2'($urandom);
            run_cycle(e, g);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL b2b_%0d: got %h required %h", i, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        m_t e, g;
        @(negedge clk);
        clear_inputs();
        RegWriteE = 1'b1; RD_E = 5'd7; RD1_E = 32'd40; RD2_E = 32'd2; PCPlus4E = 32'h20;
        run_cycle(e, g);
        vectors++;
        if (g !== e || RegWriteM !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_op: got %h required %h", g, e);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        g = dut_m();
        vectors++;
        if (g !== '0) begin
            miscompares++;
            $display("FAIL async_reset_clear: got %h required 0", g);
        end
        PCE = 32'h200; ImmExtE = 32'h10; JumpE = 1'b1;
        #1;
        vectors++;
        if (PCTargetE !== 32'h210 || PCSrcE !== 1'b1) begin
            miscompares++;
            $display("FAIL comb_in_reset: got target=%h pcsrc=%b required 00000210 1", PCTargetE, PCSrcE);
        end
        @(posedge clk); #1;
        g = dut_m();
        vectors++;
        if (g !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h required 0", g);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        mdl_alu_m = 32'd0;
        sb.delete();
        RD1_E = 32'd3; ForwardB_E = 2'b10; RD_E = 5'd4;
        run_cycle(e, g);
        vectors++;
        if (g !== e || g.wd !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_first: got %h required %h", g, e);
        end
    endtask

    // Test sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_alu_m   = 32'd0;
        test_reset();
        test_add();
        test_forwarding();
        test_branch();
        test_store();
        test_compare_ops();
        test_alu_ops();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
